// File: rtl/dna_pkg.sv
// Shared types and mod-4 digit arithmetic for the
// base-4 (DNA) word pipeline.
package dna_pkg;

  typedef logic [1:0] digit_t;

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } codec_mode_e;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_e;

  function automatic digit_t mod4_add(
    input digit_t a,
    input digit_t b
  );
    return a + b;
  endfunction

  function automatic digit_t mod4_sub(
    input digit_t a,
    input digit_t b
  );
    return a - b;
  endfunction

endpackage

// File: rtl/diff_word_core.sv
// Combinational differential encode/decode of one word.
// Digit N-1 is coded first; ref_nxt carries into the next word.
module diff_word_core
  import dna_pkg::*;
#(
  parameter int N = 8
) (
  input  codec_mode_e      mode,
  input  digit_t           prev,
  input  logic [2*N-1:0]   word,
  output logic [2*N-1:0]   code,
  output digit_t           ref_nxt
);

  digit_t up;
  digit_t din;
  digit_t dout;

  // up tracks the raw digit on encode and the decoded digit on decode
  always_comb begin
    code = '0;
    up   = prev;
    din  = '0;
    dout = '0;
    for (int i = N - 1; i >= 0; i--) begin
      din = word[2*i +: 2];
      if (mode == ENC) begin
        dout = mod4_sub(din, up);
        up   = din;
      end else begin
        dout = mod4_add(din, up);
        up   = dout;
      end
      code[2*i +: 2] = dout;
    end
    ref_nxt = up;
  end

endmodule

// File: rtl/diff_stream_codec.sv
// Streaming differential codec: frame FSM, carried reference,
// word counter and a one-deep registered output stage.
module diff_stream_codec
  import dna_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [2*N-1:0]   s_data,
  input  logic             s_sof,
  input  logic             s_eof,
  input  logic             mode,
  input  logic [1:0]       seed,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [2*N-1:0]   m_data,
  output logic             m_sof,
  output logic             m_eof,
  output logic             m_mode,
  output logic [CNT_W-1:0] m_word_cnt
);

  frame_state_e     state_q, state_d;
  digit_t           ref_q, ref_d;
  logic             m_valid_q, m_valid_d;
  logic [2*N-1:0]   m_data_q, m_data_d;
  logic             m_sof_q, m_sof_d;
  logic             m_eof_q, m_eof_d;
  logic             m_mode_q, m_mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             acc;
  logic             start;
  codec_mode_e      mode_sel;
  digit_t           prev;
  logic [2*N-1:0]   code;
  digit_t           ref_nxt;

  diff_word_core #(
    .N (N)
  ) u_core (
    .mode    (mode_sel),
    .prev    (prev),
    .word    (s_data),
    .code    (code),
    .ref_nxt (ref_nxt)
  );

  // The output register doubles as the frame's mode and counter store
  always_comb begin
    s_ready  = !m_valid_q || m_ready;
    acc      = s_valid && s_ready;
    start    = (state_q == IDLE) || s_sof;
    mode_sel = start ? codec_mode_e'(mode)
                     : codec_mode_e'(m_mode_q);
    prev     = start ? digit_t'(seed) : ref_q;

    state_d   = state_q;
    ref_d     = ref_q;
    m_valid_d = m_valid_q && !m_ready;
    m_data_d  = m_data_q;
    m_sof_d   = m_sof_q;
    m_eof_d   = m_eof_q;
    m_mode_d  = m_mode_q;
    cnt_d     = cnt_q;

    if (acc) begin
      m_valid_d = 1'b1;
      m_data_d  = code;
      m_sof_d   = s_sof;
      m_eof_d   = s_eof;
      m_mode_d  = mode_sel;
      ref_d     = ref_nxt;
      state_d   = s_eof ? IDLE : IN_FRAME;
      if (start)
        cnt_d = '0;
      else if (!(&cnt_q))
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ref_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sof_q   <= 1'b0;
      m_eof_q   <= 1'b0;
      m_mode_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_sof_q   <= m_sof_d;
      m_eof_q   <= m_eof_d;
      m_mode_q  <= m_mode_d;
      cnt_q     <= cnt_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_sof      = m_sof_q;
  assign m_eof      = m_eof_q;
  assign m_mode     = m_mode_q;
  assign m_word_cnt = cnt_q;

endmodule

// File: tb/tb_diff_stream_codec.sv
// Directed bench for diff_stream_codec with hand-computed
// vectors and immediate assertions.
module tb_diff_stream_codec;

  localparam int N     = 8;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [2*N-1:0]   s_data;
  logic             s_sof;
  logic             s_eof;
  logic             mode;
  logic [1:0]       seed;
  logic             m_valid;
  logic             m_ready;
  logic [2*N-1:0]   m_data;
  logic             m_sof;
  logic             m_eof;
  logic             m_mode;
  logic [CNT_W-1:0] m_word_cnt;

  int n_cmp = 0;
  int n_err = 0;

  diff_stream_codec #(
    .N     (N),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_sof      (s_sof),
    .s_eof      (s_eof),
    .mode       (mode),
    .seed       (seed),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_sof      (m_sof),
    .m_eof      (m_eof),
    .m_mode     (m_mode),
    .m_word_cnt (m_word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // present one word, take one edge, drop valid
  task automatic send(
    input logic [15:0] d,
    input logic        sof,
    input logic        eof,
    input logic        md,
    input logic [1:0]  sd
  );
    s_data  = d;
    s_sof   = sof;
    s_eof   = eof;
    mode    = md;
    seed    = sd;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eof   = 1'b0;
  endtask

  task automatic chk_out(
    input string       tag,
    input logic [15:0] d,
    input logic [15:0] c,
    input logic        md
  );
    chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    chk({tag, "_data"}, 32'(m_data), 32'(d));
    chk({tag, "_cnt"}, 32'(m_word_cnt), 32'(c));
    chk({tag, "_mode"}, 32'(m_mode), 32'(md));
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_sof   = 1'b0;
    s_eof   = 1'b0;
    mode    = 1'b0;
    seed    = 2'd0;
    m_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_cnt", 32'(m_word_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // encode, two-word frame
    send(16'h1B1B, 1'b1, 1'b0, 1'b0, 2'd0);
    chk_out("enc0", 16'h1555, 16'd0, 1'b0);
    chk("enc0_sof", 32'(m_sof), 32'd1);
    send(16'h1B1B, 1'b0, 1'b1, 1'b0, 2'd0);
    chk_out("enc1", 16'h5555, 16'd1, 1'b0);
    chk("enc1_eof", 32'(m_eof), 32'd1);

    // decode round trip
    send(16'h1555, 1'b1, 1'b0, 1'b1, 2'd0);
    chk_out("dec0", 16'h1B1B, 16'd0, 1'b1);
    send(16'h5555, 1'b0, 1'b1, 1'b1, 2'd0);
    chk_out("dec1", 16'h1B1B, 16'd1, 1'b1);

    // idle cycle drains the output
    @(posedge clk);
    #1;
    chk("drain_valid", 32'(m_valid), 32'd0);

    // single-word frame, then implicit frame start
    send(16'h0000, 1'b1, 1'b1, 1'b0, 2'd2);
    chk_out("single", 16'h8000, 16'd0, 1'b0);
    send(16'h0000, 1'b0, 1'b0, 1'b0, 2'd1);
    chk_out("implicit", 16'hC000, 16'd0, 1'b0);
    send(16'h0000, 1'b0, 1'b1, 1'b0, 2'd3);
    chk_out("implicit_end", 16'h0000, 16'd1, 1'b0);

    // backpressure: second word waits 3 cycles
    send(16'h1B1B, 1'b1, 1'b0, 1'b0, 2'd0);
    chk_out("bp0", 16'h1555, 16'd0, 1'b0);
    m_ready = 1'b0;
    s_data  = 16'h1B1B;
    s_eof   = 1'b1;
    s_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_sready", 32'(s_ready), 32'd0);
      chk("bp_hold", 32'(m_data), 32'h1555);
      chk("bp_hcnt", 32'(m_word_cnt), 32'd0);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    #1;
    chk("bp_release", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_eof   = 1'b0;
    chk_out("bp1", 16'h5555, 16'd1, 1'b0);

    // mid-frame restart and ignored mode toggle
    send(16'h1B1B, 1'b1, 1'b0, 1'b0, 2'd0);
    chk_out("mf0", 16'h1555, 16'd0, 1'b0);
    send(16'h1B1B, 1'b1, 1'b0, 1'b0, 2'd1);
    chk_out("mf_sof", 16'hD555, 16'd0, 1'b0);
    send(16'h1B1B, 1'b0, 1'b0, 1'b1, 2'd2);
    chk_out("mf_tog", 16'h5555, 16'd1, 1'b0);
    send(16'h1B1B, 1'b0, 1'b0, 1'b1, 2'd2);
    chk_out("mf_cnt2", 16'h5555, 16'd2, 1'b0);

    // asynchronous reset mid-frame with output pending
    m_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(m_valid), 32'd0);
    chk("ar_data", 32'(m_data), 32'd0);
    chk("ar_cnt", 32'(m_word_cnt), 32'd0);
    chk("ar_mode", 32'(m_mode), 32'd0);
    chk("ar_sof", 32'(m_sof), 32'd0);
    chk("ar_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    send(16'h1B1B, 1'b0, 1'b0, 1'b0, 2'd0);
    chk_out("post_rst", 16'h1555, 16'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/diff_stream_codec.md
# diff_stream_codec

Streaming, parametrised differential codec for base-4 (DNA) words, N 2-bit digits per word. It encodes (digit minus predecessor, mod 4) or decodes (running sum, mod 4) word streams under a valid/ready handshake. The reference digit is carried across the words of a frame, so a multi-word strand is coded as one continuous sequence. It sits between the word packer and the strand formatter, and supersedes the single-word, fixed-encode differential stage.

## Interface
- `N`, 8: digits per word; word width 2*N.
- `CNT_W`, 16: width of the in-frame word counter.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `s_valid` input 1: input word valid.
- `s_ready` output 1: block can accept an input word.
- `s_data` input 2N: input word; digit i = bits [2i+1:2i], digit N-1 is first in the sequence.
- `s_sof` input 1: word starts a frame.
- `s_eof` input 1: word ends a frame.
- `mode` input 1: 0 = encode, 1 = decode; sampled only at frame start.
- `seed` input 2: reference digit used before the first digit of a frame; sampled at frame start.
- `m_valid` output 1: output word valid.
- `m_ready` input 1: downstream accepts the output word.
- `m_data` output 2N: coded word.
- `m_sof` / `m_eof` outputs 1: frame markers aligned with `m_data`.
- `m_mode` output 1: mode used for this word.
- `m_word_cnt` output CNT_W: index of the word within its frame; 0 for the first word.

## Operation
- Clock `clk`; reset `rst_n` is asynchronous and active-low.
- Input transfer occurs when `s_valid && s_ready`. Output transfer occurs when `m_valid && m_ready`.
- Frame FSM has two states, IDLE and IN_FRAME; the reset state is IDLE.
  - An accepted word is a frame start if the FSM is IDLE or `s_sof`=1. Otherwise the word continues the frame.
  - At frame start the block latches `mode` and `seed`: `ref` is set to `seed`, the mode register is loaded, and the counter is cleared.
  - An accepted word with `s_eof`=1 moves the FSM to IDLE. Otherwise the FSM moves to IN_FRAME.
  - `s_sof`=1 while IN_FRAME restarts the frame; this is not an error.
  - `s_sof`=`s_eof`=1 is a single-word frame.
- `prev` is `seed` for a frame-start word, else `ref`.
- Encode:
  - out[N-1] = (in[N-1] - prev) mod 4.
  - out[i] = (in[i] - in[i+1]) mod 4 for i < N-1.
  - After the word, `ref` is updated to in[0] (raw input digit).
- Decode:
  - out[N-1] = (in[N-1] + prev) mod 4.
  - out[i] = (in[i] + out[i+1]) mod 4, a ripple chain.
  - After the word, `ref` is updated to out[0] (decoded digit).
- All arithmetic is 2-bit and wraps modulo 4; there are no carries out.
- `ref`, the FSM state and the counter update only on an input transfer.
- Word counter: 0 at frame start, +1 per continuing word, saturates at 2^CNT_W-1.
- `m_sof`, `m_eof`, `m_mode` and `m_word_cnt` are registered together with `m_data`.

## Timing
- Latency is 1 cycle. A word accepted at edge k appears on `m_data` with `m_valid`=1 after edge k.
- `s_ready` = !`m_valid` || `m_ready`, combinational. This gives full throughput, one word per cycle.
- While `m_valid`=1 and `m_ready`=0, all `m_*` outputs are held stable.
- `m_valid` clears after an output transfer with no simultaneous input transfer.
- Reset values: `m_valid`=0, `m_data`=0, `m_sof`=0, `m_eof`=0, `m_mode`=0, `m_word_cnt`=0, `ref`=0, FSM=IDLE. `s_ready`=1 while in reset.
- Reset mid-frame discards the in-flight word and the carried reference. The first word after reset is a frame start.
- `mode`/`seed` changes on non-frame-start words have no effect.

## Structure
- Shared package `dna_pkg`:
  - `digit_t` (logic [1:0]).
  - `codec_mode_e` (ENC=0, DEC=1).
  - Functions `mod4_add` and `mod4_sub`.
- Sub-module `diff_word_core`: purely combinational. Inputs are mode, prev and word; outputs are the coded word and the next reference digit. The top level holds the FSM, `ref`, the counter and the output register.

## Test plan
- Encode, N=8, seed 0, two-word frame 16'h1B1B (sof), then 16'h1B1B (eof) -> `m_data` 16'h1555 then 16'h5555; `m_word_cnt` 0 then 1.
- Decode, seed 0, frame 16'h1555 (sof), then 16'h5555 (eof) -> 16'h1B1B twice. Round trip matches the original.
- Single-word frame, sof=eof=1, seed 2, encode 16'h0000 -> 16'h8000. The next word without sof is treated as a frame start using its own seed.
- Backpressure: `m_ready`=0 for 3 cycles with `s_valid`=1 -> `s_ready`=0 and `m_data` stable. `ref` is not advanced; the resumed stream gives identical output to the no-stall run.
- Mid-frame `s_sof` with seed 1 -> `prev` becomes 1 and the counter returns to 0. Toggling `mode` mid-frame without sof -> `m_mode` unchanged.
- Assert `rst_n` low mid-frame with `m_valid`=1 -> all outputs are 0 immediately. The next word uses `seed`, not the stale `ref`.
